// File: rtl/mdu_unit.sv
// mdu_unit: execute-stage multiply/divide unit that owns the HI/LO registers.
//
// Runs mult/multu/div/divu as multi-cycle operations. The result is computed
// at the start edge and held in pending registers. It is committed to HI/LO
// when the cycle counter expires. mthi/mtlo write HI/LO in a single cycle.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous, active-high reset
//   start    valid MDU op in E stage (single-cycle strobe)
//   op       decoder ALU op: 3=mult, 8=multu, 4=div, 9=divu, 10=mthi, 11=mtlo
//   rs_val   forwarded rs operand (dividend / multiplicand / mthi-mtlo source)
//   rt_val   forwarded rt operand (divisor / multiplier)
//   busy     multi-cycle operation in progress (for the stall unit)
//   hi, lo   architectural HI/LO registers (no bypass of pending results)
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd3;
  localparam logic [3:0] OP_MULTU = 4'd8;
  localparam logic [3:0] OP_DIV   = 4'd4;
  localparam logic [3:0] OP_DIVU  = 4'd9;
  localparam logic [3:0] OP_MTHI  = 4'd10;
  localparam logic [3:0] OP_MTLO  = 4'd11;

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_RUN  = 1'b1;

  localparam logic [4:0] MULT_COUNT = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_COUNT  = 5'(DIV_CYCLES);

  logic        state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pendHi_q, pendHi_d;
  logic [31:0] pendLo_q, pendLo_d;
  logic        pendWrite_q, pendWrite_d;

  logic [63:0] prodSigned;
  logic [63:0] prodUnsigned;
  logic [31:0] absRs, absRt;
  logic [31:0] divisorU, divisorS;
  logic [31:0] quotU, remU;
  logic [31:0] quotMag, remMag;
  logic [31:0] quotS, remS;

  // Both products are formed at full 64-bit width from explicitly extended
  // operands so the upper half is exact for signed and unsigned forms.
  assign prodSigned   = $signed({{32{rs_val[31]}}, rs_val}) *
                        $signed({{32{rt_val[31]}}, rt_val});
  assign prodUnsigned = {32'd0, rs_val} * {32'd0, rt_val};

  // Signed division works on magnitudes and reapplies signs afterwards:
  // the quotient is negative when operand signs differ, and the remainder
  // takes the dividend's sign. 0x80000000 / -1 falls out as 0x80000000 rem 0
  // because the magnitude 2^31 fits the unsigned datapath.
  // A zero divisor is replaced by 1 only to keep the datapath defined; such
  // results are never committed.
  assign absRs    = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
  assign absRt    = rt_val[31] ? (~rt_val + 32'd1) : rt_val;
  assign divisorU = (rt_val == 32'd0) ? 32'd1 : rt_val;
  assign divisorS = (absRt == 32'd0) ? 32'd1 : absRt;
  assign quotU    = rs_val / divisorU;
  assign remU     = rs_val % divisorU;
  assign quotMag  = absRs / divisorS;
  assign remMag   = absRs % divisorS;
  assign quotS    = (rs_val[31] ^ rt_val[31]) ? (~quotMag + 32'd1) : quotMag;
  assign remS     = rs_val[31] ? (~remMag + 32'd1) : remMag;

  // Next-state logic. Starts are only honoured in IDLE, so a start strobe
  // during RUN leaves every register untouched. On the final RUN cycle the
  // pending result is committed unless the op was a divide by zero.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    pendHi_d    = pendHi_q;
    pendLo_d    = pendLo_q;
    pendWrite_d = pendWrite_q;

    if (state_q == STATE_IDLE) begin
      if (start) begin
        case (op)
          OP_MULT: begin
            pendHi_d    = prodSigned[63:32];
            pendLo_d    = prodSigned[31:0];
            pendWrite_d = 1'b1;
            count_d     = MULT_COUNT;
            state_d     = STATE_RUN;
          end
          OP_MULTU: begin
            pendHi_d    = prodUnsigned[63:32];
            pendLo_d    = prodUnsigned[31:0];
            pendWrite_d = 1'b1;
            count_d     = MULT_COUNT;
            state_d     = STATE_RUN;
          end
          OP_DIV: begin
            pendHi_d    = remS;
            pendLo_d    = quotS;
            pendWrite_d = (rt_val != 32'd0);
            count_d     = DIV_COUNT;
            state_d     = STATE_RUN;
          end
          OP_DIVU: begin
            pendHi_d    = remU;
            pendLo_d    = quotU;
            pendWrite_d = (rt_val != 32'd0);
            count_d     = DIV_COUNT;
            state_d     = STATE_RUN;
          end
          OP_MTHI: hi_d = rs_val;
          OP_MTLO: lo_d = rs_val;
          default: ;
        endcase
      end
    end else begin
      if (count_q == 5'd1) begin
        if (pendWrite_q) begin
          hi_d = pendHi_q;
          lo_d = pendLo_q;
        end
        count_d = 5'd0;
        state_d = STATE_IDLE;
      end else begin
        count_d = count_q - 5'd1;
      end
    end
  end

  // State registers. Reset clears pending results too, so an aborted
  // operation can never commit later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= STATE_IDLE;
      count_q     <= 5'd0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      pendHi_q    <= 32'd0;
      pendLo_q    <= 32'd0;
      pendWrite_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      pendHi_q    <= pendHi_d;
      pendLo_q    <= pendLo_d;
      pendWrite_q <= pendWrite_d;
    end
  end

  assign busy = (state_q == STATE_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
Multiply/divide unit in the execute stage. It consumes the ALU op code and the register operands produced by the instruction decoder, and owns the HI/LO registers. It runs mult/multu/div/divu over multiple cycles with a busy indication for the hazard/stall logic. It also services mthi/mtlo writes and drives HI/LO for mfhi/mflo writeback selection.

Parameters:
MULT_CYCLES, 5, cycles busy is high for mult/multu (legal range 1..31)
DIV_CYCLES, 10, cycles busy is high for div/divu (legal range 1..31)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  E-stage instruction is valid and its op is an MDU op; single-cycle strobe
op  input  4  decoder ALU op: 3=mult, 8=multu, 4=div, 9=divu, 10=mthi, 11=mtlo; others ignored
rs_val  input  32  forwarded rs operand
rt_val  input  32  forwarded rt operand
busy  output  1  multi-cycle operation in progress
hi  output  32  architectural HI register
lo  output  32  architectural LO register

Behaviour:
- Reset (async, active-high): state=IDLE, counter=0, busy=0, hi=0, lo=0, pending results=0. Reset mid-operation aborts the operation; nothing commits.
- Two states: IDLE and RUN. The counter is 5 bits.
- IDLE, start=1, op in {3,8,4,9}:
  - Compute the result from rs_val/rt_val at that edge into pending_hi/pending_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN; busy=1 from the next cycle.
- RUN: counter decrements each cycle. When counter==1 at an edge: hi<=pending_hi, lo<=pending_lo, busy<=0, state<=IDLE. Busy is therefore high for exactly N cycles after the start edge. New HI/LO values are visible in the first cycle busy is low.
- mthi (10) / mtlo (11) with start=1 in IDLE: hi<=rs_val (mthi) or lo<=rs_val (mtlo) at that edge. Single cycle, busy stays 0.
- start=1 while busy=1: ignored completely; no state, counter or HI/LO change. The stall unit must hold MD ops and mfhi/mflo while busy or start is high.
- start=1 with op not in the six listed codes: ignored.
- Arithmetic:
  - mult: signed 32x32 -> 64; hi = upper 32 bits, lo = lower 32 bits.
  - multu: same, unsigned.
  - div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend (rs/rt).
  - divu: unsigned quotient and remainder.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (rt_val=0), div or divu: the op still runs the full DIV_CYCLES busy period, but HI and LO keep their prior values at commit.
- hi/lo outputs are direct register values, with no bypass of pending results.

Test Plan:
- Reset, then mult with rs=0xFFFFFFFF (-1), rt=0x00000002 -> busy high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE. Same operands with multu -> hi=0x00000001, lo=0xFFFFFFFE.
- div with rs=0xFFFFFFF9 (-7), rt=2 -> busy high for 10 cycles; then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). divu with rs=7, rt=2 -> lo=3, hi=1.
- mthi rs=0x12345678, then mtlo rs=0x9ABCDEF0 on consecutive cycles -> hi/lo updated on each edge; busy never asserts.
- Start div; pulse start with mult (rs=3, rt=3) mid-run -> second op ignored; final lo=quotient of the div; busy low exactly 10 cycles after the first start.
- Preload hi=5, lo=6 via mthi/mtlo; div with rt=0 -> busy for 10 cycles; hi=5, lo=6 unchanged. div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start multu; assert reset asynchronously at cycle 2 -> busy, hi, lo go to 0 immediately and stay 0 after reset release with no later commit.
